// File: rtl/conv_encoder_tx.sv
// Rate-1/2 convolutional encoder with an input FIFO and a registered symbol output.
// Zero-tail frame termination is built only when CONV_ENC_TAIL_EN is defined.
module conv_encoder_tx #(
  parameter int unsigned    K     = 3,
  parameter logic [K-1:0]   G0    = 3'b111,
  parameter logic [K-1:0]   G1    = 3'b101,
  parameter int unsigned    DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_bit,
  input  logic       in_last,
  output logic       in_ready,
  output logic       sym_valid,
  output logic [1:0] sym,
  output logic       sym_last,
  input  logic       sym_ready,
  output logic       busy,
  output logic [7:0] sym_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned HW = K - 1;
`ifdef CONV_ENC_TAIL_EN
  localparam int unsigned TW = (K > 2) ? $clog2(K) : 1;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA
`ifdef CONV_ENC_TAIL_EN
    , S_TAIL
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    mem_q [DEPTH];
  logic [1:0]    mem_d [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [HW-1:0] hist_q, hist_d;
  logic [1:0]    sym_q, sym_d;
  logic          sym_valid_q, sym_valid_d;
  logic          sym_last_q, sym_last_d;
  logic [7:0]    sym_count_q, sym_count_d;
`ifdef CONV_ENC_TAIL_EN
  logic [TW-1:0] tail_cnt_q, tail_cnt_d;
`endif

  logic       fifo_empty;
  logic       fifo_full;
  logic       push;
  logic       pop;
  logic       slot_free;
  logic       handshake;
  logic [1:0] head;

  function automatic logic [1:0] encode(input logic b, input logic [HW-1:0] h);
    logic [K-1:0] r;
    r = {b, h};
    return {^(r & G0), ^(r & G1)};
  endfunction

  // New bit enters at the top; the oldest history bit falls off the bottom.
  function automatic logic [HW-1:0] advance(input logic b, input logic [HW-1:0] h);
    logic [K-1:0] r;
    r = {b, h};
    return r[K-1:1];
  endfunction

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head       = mem_q[rd_ptr_q[AW-1:0]];
  assign in_ready   = !fifo_full;
  assign push       = in_valid && !fifo_full;
  assign slot_free  = !sym_valid_q || sym_ready;
  assign handshake  = sym_valid_q && sym_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = {in_last, in_bit};
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    sym_d       = sym_q;
    sym_valid_d = sym_valid_q;
    sym_last_d  = sym_last_q;
    pop         = 1'b0;
`ifdef CONV_ENC_TAIL_EN
    tail_cnt_d  = tail_cnt_q;
`endif
    if (slot_free) begin
      sym_valid_d = 1'b0;
      sym_last_d  = 1'b0;
      case (state_q)
        S_IDLE, S_DATA: begin
          if (!fifo_empty) begin
            pop         = 1'b1;
            sym_d       = encode(head[0], hist_q);
            sym_valid_d = 1'b1;
            hist_d      = advance(head[0], hist_q);
            state_d     = S_DATA;
            if (head[1]) begin
`ifdef CONV_ENC_TAIL_EN
              state_d    = S_TAIL;
              tail_cnt_d = '0;
`else
              sym_last_d = 1'b1;
              hist_d     = '0;
              state_d    = S_IDLE;
`endif
            end
          end
        end
`ifdef CONV_ENC_TAIL_EN
        S_TAIL: begin
          sym_d       = encode(1'b0, hist_q);
          sym_valid_d = 1'b1;
          hist_d      = advance(1'b0, hist_q);
          tail_cnt_d  = tail_cnt_q + 1'b1;
          if (tail_cnt_q == TW'(K - 2)) begin
            sym_last_d = 1'b1;
            hist_d     = '0;
            state_d    = S_IDLE;
          end
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    sym_count_d = sym_count_q;
    if (handshake) begin
      if (sym_last_q) begin
        sym_count_d = '0;
      end else if (sym_count_q != 8'hFF) begin
        sym_count_d = sym_count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      hist_q      <= '0;
      sym_q       <= '0;
      sym_valid_q <= 1'b0;
      sym_last_q  <= 1'b0;
      sym_count_q <= '0;
`ifdef CONV_ENC_TAIL_EN
      tail_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      hist_q      <= hist_d;
      sym_q       <= sym_d;
      sym_valid_q <= sym_valid_d;
      sym_last_q  <= sym_last_d;
      sym_count_q <= sym_count_d;
`ifdef CONV_ENC_TAIL_EN
      tail_cnt_q  <= tail_cnt_d;
`endif
    end
  end

  assign sym_valid = sym_valid_q;
  assign sym       = sym_q;
  assign sym_last  = sym_last_q;
  assign sym_count = sym_count_q;
  assign busy      = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_conv_encoder_tx.sv
// Self-checking bench for conv_encoder_tx: directed frames plus randomized traffic
// scored against an arithmetic encoder model; follows CONV_ENC_TAIL_EN like the design.
`timescale 1ns/1ps
module tb_conv_encoder_tx;

  localparam int         K     = 3;
  localparam logic [2:0] G0    = 3'b111;
  localparam logic [2:0] G1    = 3'b101;
  localparam int         DEPTH = 4;
`ifdef CONV_ENC_TAIL_EN
  localparam bit TAIL_EN = 1'b1;
`else
  localparam bit TAIL_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic       sym_valid;
  logic [1:0] sym;
  logic       sym_last;
  logic       sym_ready = 1'b0;
  logic       busy;
  logic [7:0] sym_count;

  always #5 clk = ~clk;

  conv_encoder_tx #(.K(K), .G0(G0), .G1(G1), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_bit(in_bit), .in_last(in_last), .in_ready(in_ready),
    .sym_valid(sym_valid), .sym(sym), .sym_last(sym_last), .sym_ready(sym_ready),
    .busy(busy), .sym_count(sym_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: encoder state as an integer, symbols queued as {last, sym}.
  int unsigned mstate = 0;
  int unsigned cnt_m  = 0;
  logic [2:0]  exp_q[$];

  function automatic logic [1:0] ref_sym(input int unsigned r);
    logic [1:0] s;
    s[1] = ($countones(r & 32'(G0)) % 2) == 1;
    s[0] = ($countones(r & 32'(G1)) % 2) == 1;
    return s;
  endfunction

  task automatic model_push(input logic b, input logic l);
    int unsigned r;
    r = (32'(b) << (K - 1)) | mstate;
    exp_q.push_back({l && !TAIL_EN, ref_sym(r)});
    mstate = r >> 1;
    if (l) begin
      if (TAIL_EN) begin
        for (int i = 0; i < K - 1; i++) begin
          r = mstate;
          exp_q.push_back({i == K - 2, ref_sym(r)});
          mstate = r >> 1;
        end
      end
      mstate = 0;
    end
  endtask

  int rdy_mode = 0;  // 0 always ready, 1 toggle, 2 random, 3 held low
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: sym_ready = 1'b1;
        1: sym_ready = ~sym_ready;
        2: sym_ready = 1'($urandom_range(0, 1));
        default: sym_ready = 1'b0;
      endcase
    end
  end

  int         hs_cnt = 0;
  logic [2:0] obs_log[$];
  logic       prev_stall = 1'b0;
  logic [2:0] prev_out;

  initial begin
    logic [2:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check_eq("hold_valid", 32'(sym_valid), 32'd1);
          check_eq("hold_sym", 32'({sym_last, sym}), 32'(prev_out));
        end
        if (sym_valid && sym_ready) begin
          hs_cnt++;
          obs_log.push_back({sym_last, sym});
          if (exp_q.size() == 0) begin
            check_eq("extra_sym_queue_size", 32'(exp_q.size()), 32'd1);
            e = 3'b000;
          end else begin
            e = exp_q.pop_front();
            check_eq("sym", 32'({sym_last, sym}), 32'(e));
          end
          check_eq("sym_count", 32'(sym_count), cnt_m);
          cnt_m = e[2] ? 0 : ((cnt_m == 255) ? 255 : cnt_m + 1);
        end
        prev_stall = sym_valid && !sym_ready;
        prev_out   = {sym_last, sym};
      end
    end
  end

  task automatic realign();
    @(posedge clk); #1;
  endtask

  task automatic push_bit(input logic b, input logic l);
    int unsigned w = 0;
    in_valid = 1'b1; in_bit = b; in_last = l;
    @(negedge clk);
    while (!in_ready && w < 1000) begin
      w++;
      @(negedge clk);
    end
    if (!in_ready) check_eq("push_timeout", 32'(in_ready), 32'd1);
    else model_push(b, l);
    realign();
    in_valid = 1'b0;
  endtask

  // Ends on a negedge so callers can sample right after the final handshake.
  task automatic wait_drain(input string tag);
    int unsigned w = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || sym_valid) && w < 3000) begin
      w++;
      @(negedge clk);
    end
    check_eq(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic compare_log(input string tag, input logic [2:0] ref_q[$]);
    check_eq({tag, "_len"}, 32'(obs_log.size()), 32'(ref_q.size()));
    for (int i = 0; i < ref_q.size() && i < obs_log.size(); i++) begin
      check_eq($sformatf("%s_%0d", tag, i), 32'(obs_log[i]), 32'(ref_q[i]));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_sym_valid"}, 32'(sym_valid), 32'd0);
    check_eq({tag, "_sym"},       32'(sym),       32'd0);
    check_eq({tag, "_sym_last"},  32'(sym_last),  32'd0);
    check_eq({tag, "_sym_count"}, 32'(sym_count), 32'd0);
    check_eq({tag, "_busy"},      32'(busy),      32'd0);
    check_eq({tag, "_in_ready"},  32'(in_ready),  32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] t1_ref[$];
    logic [2:0] t4_ref[$];
    logic [2:0] t5_ref[$];
    logic [2:0] t6_pre[$];
    int unsigned acc;
    int unsigned base;
    int unsigned w;
    logic b;

`ifdef CONV_ENC_TAIL_EN
    t1_ref = '{3'b011, 3'b010, 3'b000, 3'b001, 3'b001, 3'b111};
    t4_ref = '{3'b011, 3'b010, 3'b111};
    t5_ref = '{3'b011, 3'b010, 3'b111, 3'b000, 3'b000, 3'b100};
`else
    t1_ref = '{3'b011, 3'b010, 3'b000, 3'b101};
    t4_ref = '{3'b111};
    t5_ref = '{3'b111, 3'b100};
`endif
    t6_pre = '{3'b011, 3'b010};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    realign();

    // T1: reference frame, always ready, plus input-to-output latency
    obs_log.delete();
    push_bit(1'b1, 1'b0);
    @(negedge clk);
    check_eq("latency_t1", 32'(sym_valid), 32'd0);
    @(negedge clk);
    check_eq("latency_t2", 32'(sym_valid), 32'd1);
    realign();
    push_bit(1'b0, 1'b0);
    push_bit(1'b1, 1'b0);
    push_bit(1'b1, 1'b1);
    wait_drain("t1_drain");
    compare_log("t1", t1_ref);
    check_eq("t1_count_end", 32'(sym_count), 32'd0);
    realign();

    // T2: same frame under a toggling ready
    obs_log.delete();
    rdy_mode = 1;
    push_bit(1'b1, 1'b0);
    push_bit(1'b0, 1'b0);
    push_bit(1'b1, 1'b0);
    push_bit(1'b1, 1'b1);
    wait_drain("t2_drain");
    compare_log("t2", t1_ref);
    realign();

    // T3: backpressure capacity is FIFO depth plus the output register
    rdy_mode = 3;
    repeat (3) realign();
    acc = 0;
    for (int i = 0; i < 16; i++) begin
      b = 1'($urandom_range(0, 1));
      in_valid = 1'b1; in_bit = b; in_last = 1'b0;
      @(negedge clk);
      if (!in_ready) break;
      model_push(b, 1'b0);
      acc++;
      realign();
    end
    in_valid = 1'b0;
    check_eq("t3_accepted", acc, 32'(DEPTH + 1));
    check_eq("t3_busy", 32'(busy), 32'd1);
    realign();
    rdy_mode = 0;
    push_bit(1'b1, 1'b1);
    wait_drain("t3_drain");
    realign();

    // T4: single-bit frame
    obs_log.delete();
    push_bit(1'b1, 1'b1);
    wait_drain("t4_drain");
    check_eq("t4_busy", 32'(busy), 32'd0);
    check_eq("t4_count_end", 32'(sym_count), 32'd0);
    compare_log("t4", t4_ref);
    realign();

    // T5: back-to-back single-bit frames
    obs_log.delete();
    push_bit(1'b1, 1'b1);
    push_bit(1'b0, 1'b1);
    wait_drain("t5_drain");
    compare_log("t5", t5_ref);
    realign();

    // T6: reset after two symbols of a frame
    obs_log.delete();
    rdy_mode = 3;
    repeat (2) realign();
    push_bit(1'b1, 1'b0);
    push_bit(1'b0, 1'b0);
    push_bit(1'b1, 1'b0);
    push_bit(1'b1, 1'b1);
    base = hs_cnt;
    rdy_mode = 0;
    w = 0;
    @(negedge clk);
    while (hs_cnt < base + 2 && w < 100) begin
      w++;
      @(negedge clk);
    end
    check_eq("t6_two_symbols", hs_cnt - base, 32'd2);
    realign();
    rst = 1'b1;
    realign();
    rst = 1'b0;
    exp_q.delete();
    mstate = 0;
    cnt_m  = 0;
    @(negedge clk);
    check_reset_outputs("t6_reset");
    compare_log("t6_pre", t6_pre);
    realign();
    obs_log.delete();
    push_bit(1'b1, 1'b1);
    wait_drain("t6_drain");
    compare_log("t6_post", t4_ref);
    realign();

    // Randomized frames with random ready and input gaps, no drain between frames
    for (int f = 0; f < 14; f++) begin
      int unsigned len;
      len = $urandom_range(1, 12);
      rdy_mode = $urandom_range(0, 2);
      for (int unsigned i = 0; i < len; i++) begin
        push_bit(1'($urandom_range(0, 1)), i == len - 1);
        repeat ($urandom_range(0, 2)) realign();
      end
    end
    rdy_mode = 0;
    wait_drain("rand_drain");
    realign();

    // Long frame drives sym_count into saturation
    for (int i = 0; i < 270; i++) begin
      push_bit(1'($urandom_range(0, 1)), i == 269);
    end
    wait_drain("long_drain");
    check_eq("long_count_end", 32'(sym_count), 32'd0);
    check_eq("long_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
